// File: rtl/cnt_pkg.sv
// Shared types and defaults for the parametrised up/down counter.
//   mode_e   : boundary behaviour selector (WRAP / SAT / ONESHOT / reserved)
//   state_e  : ONESHOT run-control states
//   CNT_WIDTH: default counter width used by the design and its bench
package cnt_pkg;

  localparam int CNT_WIDTH = 4;

  typedef enum logic [1:0] {
    MODE_WRAP    = 2'd0,
    MODE_SAT     = 2'd1,
    MODE_ONESHOT = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/updown_counter_param_next_calc.sv
// cnt_next_calc: combinational next-count and boundary-event logic for one
// enabled step of the counter.
//   count_i   : current count
//   max_val_i : terminal value (range is 0..max_val_i)
//   up_dn_i   : 1 = up, 0 = down
//   mode_i    : boundary behaviour
//   nxt_o     : count after an enabled step
//   ovf_evt_o : up-count boundary event on this step
//   unf_evt_o : down-count boundary event on this step
module cnt_next_calc
  import cnt_pkg::*;
#(
  parameter int DATA_W = CNT_WIDTH
) (
  input  logic [DATA_W-1:0] count_i,
  input  logic [DATA_W-1:0] max_val_i,
  input  logic              up_dn_i,
  input  mode_e             mode_i,
  output logic [DATA_W-1:0] nxt_o,
  output logic              ovf_evt_o,
  output logic              unf_evt_o
);

  localparam logic [DATA_W-1:0] ONE = DATA_W'(1);

  logic wrap_like;
  assign wrap_like = (mode_i == MODE_WRAP) || (mode_i == MODE_RSVD);

  always_comb begin
    nxt_o     = count_i;
    ovf_evt_o = 1'b0;
    unf_evt_o = 1'b0;
    if (up_dn_i) begin
      if (count_i < max_val_i) begin
        nxt_o = count_i + ONE;
      end else begin
        // Also reached when max_val was lowered below the current count.
        ovf_evt_o = 1'b1;
        nxt_o     = wrap_like ? '0 : max_val_i;
      end
    end else begin
      if (count_i > max_val_i) begin
        // Out of range after max_val shrank: pull back in, not an event.
        nxt_o = max_val_i;
      end else if (count_i != '0) begin
        nxt_o = count_i - ONE;
      end else begin
        unf_evt_o = 1'b1;
        nxt_o     = wrap_like ? max_val_i : '0;
      end
    end
  end

endmodule

// File: rtl/updown_counter_param.sv
// updown_counter_param: loadable up/down counter with programmable terminal
// value, WRAP / SAT / ONESHOT boundary modes, terminal-count pulse and sticky
// overflow/underflow flags. All outputs are registered.
//   clk       : clock, rising edge
//   rst       : asynchronous reset, active low
//   en        : count enable
//   load      : load d_in (clamped to max_val), priority over en
//   d_in      : load value
//   up_dn     : 1 = up, 0 = down
//   mode      : 0 WRAP, 1 SAT, 2 ONESHOT, 3 reserved (as WRAP)
//   max_val   : terminal value
//   clr_flags : clear ovf/unf (a same-cycle event wins)
//   count     : current count
//   tc        : one-cycle pulse per boundary event
//   ovf / unf : sticky boundary flags
//   busy/done : ONESHOT FSM in RUN / DONE
module updown_counter_param
  import cnt_pkg::*;
#(
  parameter int WIDTH   = CNT_WIDTH,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [WIDTH-1:0] d_in,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] max_val,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             unf,
  output logic             busy,
  output logic             done
);

  localparam logic [WIDTH-1:0] RST_C = RST_VAL[WIDTH-1:0];

  function automatic logic [WIDTH-1:0] clamp_to_max(input logic [WIDTH-1:0] v,
                                                   input logic [WIDTH-1:0] m);
    return (v > m) ? m : v;
  endfunction

  mode_e            md;
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] step_nxt;
  logic             ovf_evt, unf_evt;
  logic             step_en;
  logic             oneshot;

  assign md      = mode_e'(mode);
  assign oneshot = (md == MODE_ONESHOT);
  // In ONESHOT only RUN may count; IDLE and DONE ignore en.
  assign step_en = en && !load && (!oneshot || (state_q == S_RUN));

  cnt_next_calc #(
    .DATA_W (WIDTH)
  ) u_next_calc (
    .count_i   (count_q),
    .max_val_i (max_val),
    .up_dn_i   (up_dn),
    .mode_i    (md),
    .nxt_o     (step_nxt),
    .ovf_evt_o (ovf_evt),
    .unf_evt_o (unf_evt)
  );

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= S_IDLE;
    else      state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    if (!oneshot) begin
      state_d = S_IDLE;
    end else if (load) begin
      state_d = S_RUN;
    end else if ((state_q == S_RUN) && step_en && (ovf_evt || unf_evt)) begin
      state_d = S_DONE;
    end
  end

  // FSM outputs, decoded straight from the state register
  always_comb begin
    busy = (state_q == S_RUN);
    done = (state_q == S_DONE);
  end

  // Datapath next state
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = clr_flags ? 1'b0 : ovf_q;
    unf_d   = clr_flags ? 1'b0 : unf_q;
    if (load) begin
      count_d = clamp_to_max(d_in, max_val);
    end else if (step_en) begin
      count_d = step_nxt;
      tc_d    = ovf_evt || unf_evt;
      if (ovf_evt) ovf_d = 1'b1;
      if (unf_evt) unf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= RST_C;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_updown_counter_param.sv
module tb_updown_counter_param;
  import cnt_pkg::*;

  localparam int W = CNT_WIDTH;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         en = 1'b0, load = 1'b0, up_dn = 1'b0, clr_flags = 1'b0;
  logic [W-1:0] d_in = '0, max_val = '0;
  logic [1:0]   mode = 2'd0;
  logic [W-1:0] count;
  logic         tc, ovf, unf, busy, done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] c;
    logic         tc, ovf, unf, busy, done;
    string        nm;
  } exp_t;

  exp_t sb[$];

  updown_counter_param #(.WIDTH(W), .RST_VAL(0)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load), .d_in(d_in), .up_dn(up_dn),
    .mode(mode), .max_val(max_val), .clr_flags(clr_flags), .count(count),
    .tc(tc), .ovf(ovf), .unf(unf), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic compare(input exp_t e);
    checks++;
    if ({count, tc, ovf, unf, busy, done} !== {e.c, e.tc, e.ovf, e.unf, e.busy, e.done}) begin
      errors++;
      $display("FAIL %s: got count=%0d tc=%b ovf=%b unf=%b busy=%b done=%b, expected count=%0d tc=%b ovf=%b unf=%b busy=%b done=%b",
               e.nm, count, tc, ovf, unf, busy, done, e.c, e.tc, e.ovf, e.unf, e.busy, e.done);
    end
  endtask

  // Monitor: after every rising edge, pop one expected response if pending.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) compare(sb.pop_front());
  end

  // Drive one cycle of inputs and queue the response expected after the next edge.
  task automatic step(input logic ld, input logic [W-1:0] d, input logic e, input logic ud,
                      input logic [1:0] md, input logic [W-1:0] mx, input logic clr,
                      input logic [W-1:0] ec, input logic etc, input logic eovf,
                      input logic eunf, input logic ebusy, input logic edone, input string nm);
    exp_t x;
    @(negedge clk);
    load = ld; d_in = d; en = e; up_dn = ud; mode = md; max_val = mx; clr_flags = clr;
    x.c = ec; x.tc = etc; x.ovf = eovf; x.unf = eunf; x.busy = ebusy; x.done = edone; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic check_now(input string nm);
    exp_t x;
    x.c = '0; x.tc = 1'b0; x.ovf = 1'b0; x.unf = 1'b0; x.busy = 1'b0; x.done = 1'b0; x.nm = nm;
    compare(x);
  endtask

  initial begin
    #1 check_now("reset_initial");
    @(negedge clk); rst = 1'b1;

    //    ld d   en ud md mx  clr   cnt tc ov un bs dn
    step(1, 5,  0, 0, 0, 15, 0,    5, 0, 0, 0, 0, 0, "load5");
    step(0, 0,  1, 1, 0, 15, 0,    6, 0, 0, 0, 0, 0, "up6");
    step(0, 0,  1, 1, 0, 15, 0,    7, 0, 0, 0, 0, 0, "up7");
    @(negedge clk); load = 0; en = 1; up_dn = 1;
    #2 rst = 1'b0;
    #1 check_now("reset_midcount");
    @(negedge clk); rst = 1'b1; en = 0;

    step(1, 9,  0, 0, 0, 15, 0,    9, 0, 0, 0, 0, 0, "load9");
    // WRAP up
    step(1, 10, 0, 0, 0, 11, 0,   10, 0, 0, 0, 0, 0, "wrap_load10");
    step(0, 0,  1, 1, 0, 11, 0,   11, 0, 0, 0, 0, 0, "wrap_up11");
    step(0, 0,  1, 1, 0, 11, 0,    0, 1, 1, 0, 0, 0, "wrap_up0");
    step(0, 0,  1, 1, 0, 11, 0,    1, 0, 1, 0, 0, 0, "wrap_up1");
    step(0, 0,  0, 1, 0, 11, 0,    1, 0, 1, 0, 0, 0, "wrap_hold");
    step(0, 0,  0, 1, 0, 11, 1,    1, 0, 0, 0, 0, 0, "wrap_clr");
    // SAT down
    step(1, 1,  0, 0, 1, 11, 0,    1, 0, 0, 0, 0, 0, "sat_load1");
    step(0, 0,  1, 0, 1, 11, 0,    0, 0, 0, 0, 0, 0, "sat_dn0");
    step(0, 0,  1, 0, 1, 11, 0,    0, 1, 0, 1, 0, 0, "sat_dn_bnd");
    step(0, 0,  1, 0, 1, 11, 1,    0, 1, 0, 1, 0, 0, "sat_dn_clr_set_wins");
    step(0, 0,  0, 0, 1, 11, 1,    0, 0, 0, 0, 0, 0, "sat_clr");
    // ONESHOT
    step(1, 1,  0, 1, 2, 3,  0,    1, 0, 0, 0, 1, 0, "os_load1");
    step(0, 0,  1, 1, 2, 3,  0,    2, 0, 0, 0, 1, 0, "os_up2");
    step(0, 0,  1, 1, 2, 3,  0,    3, 0, 0, 0, 1, 0, "os_up3");
    step(0, 0,  1, 1, 2, 3,  0,    3, 1, 1, 0, 0, 1, "os_done");
    step(0, 0,  1, 1, 2, 3,  0,    3, 0, 1, 0, 0, 1, "os_done_hold");
    step(1, 0,  0, 1, 2, 3,  0,    0, 0, 1, 0, 1, 0, "os_reload0");
    step(0, 0,  1, 0, 2, 3,  0,    0, 1, 1, 1, 0, 1, "os_dn_done");
    step(0, 0,  0, 0, 0, 3,  1,    0, 0, 0, 0, 0, 0, "os_leave");
    step(0, 0,  1, 1, 2, 3,  0,    0, 0, 0, 0, 0, 0, "os_idle_ignores_en");
    step(0, 0,  0, 1, 0, 3,  0,    0, 0, 0, 0, 0, 0, "os_exit2");
    // Range edges
    step(1, 14, 0, 0, 0, 5,  0,    5, 0, 0, 0, 0, 0, "load_clamp");
    step(0, 0,  1, 0, 0, 2,  0,    2, 0, 0, 0, 0, 0, "dn_above_max");
    step(0, 0,  1, 0, 0, 2,  0,    1, 0, 0, 0, 0, 0, "dn1");
    step(0, 0,  1, 1, 0, 0,  0,    0, 1, 1, 0, 0, 0, "max0_up_a");
    step(0, 0,  1, 1, 0, 0,  0,    0, 1, 1, 0, 0, 0, "max0_up_b");
    step(0, 0,  1, 0, 0, 0,  0,    0, 1, 1, 1, 0, 0, "max0_dn");
    step(0, 0,  0, 0, 0, 0,  1,    0, 0, 0, 0, 0, 0, "max0_clr");
    // SAT clamp on up-count above a lowered max_val
    step(1, 7,  0, 1, 1, 7,  0,    7, 0, 0, 0, 0, 0, "sat_load7");
    step(0, 0,  1, 1, 1, 4,  0,    4, 1, 1, 0, 0, 0, "sat_clamp");
    step(0, 0,  1, 1, 1, 4,  0,    4, 1, 1, 0, 0, 0, "sat_at_max");
    step(0, 0,  0, 1, 1, 4,  1,    4, 0, 0, 0, 0, 0, "sat_clr2");
    // Priority: load beats en at a boundary
    step(1, 11, 0, 1, 0, 11, 0,   11, 0, 0, 0, 0, 0, "prio_load11");
    step(1, 3,  1, 1, 0, 11, 0,    3, 0, 0, 0, 0, 0, "prio_load_over_en");
    step(0, 0,  0, 1, 0, 11, 0,    3, 0, 0, 0, 0, 0, "prio_hold");
    // WRAP down at 0, reserved mode behaves as WRAP
    step(1, 0,  0, 0, 0, 11, 0,    0, 0, 0, 0, 0, 0, "wrapdn_load0");
    step(0, 0,  1, 0, 0, 11, 0,   11, 1, 0, 1, 0, 0, "wrap_dn_to_max");
    step(0, 0,  1, 1, 3, 11, 0,    0, 1, 1, 1, 0, 0, "rsvd_wraps");
    step(0, 0,  0, 1, 0, 11, 0,    0, 0, 1, 1, 0, 0, "final_hold");

    @(negedge clk); en = 0; load = 0; clr_flags = 0;
    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    #2;
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected responses left unchecked, required 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
